a2d_sched: RTL

- Schedules and arbitrates the single shared SPI master that talks to the ADC128S A2D converter.
- Round-robins conversions over the four analog channels the Segway consumes: left load cell, right load cell, steering pot and battery.
- Holds the latest 12-bit result for each channel for auth, steering-enable and battery logic.
- Grants a second requester (host/diagnostic port) one-shot conversions of any channel between round-robin slots.

---
 rtl/a2d_sched.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/a2d_sched.sv
// a2d_sched: owns the shared SPI master in front of the ADC128S. It round-robins
// conversions over the four Segway channels and slots in one-shot host conversions.
// Each conversion is two SPI transactions: the first selects the channel, and the
// second returns the sample.
// Optional build macro: A2D_AVG_EN adds a 2-tap IIR (old + new + 1) >> 1 on the
// round-robin results.

module a2d_sched #(
  parameter logic [2:0]  CH_LFT   = 3'd0,
  parameter logic [2:0]  CH_RGHT  = 3'd4,
  parameter logic [2:0]  CH_STEER = 3'd5,
  parameter logic [2:0]  CH_BATT  = 3'd6,
  parameter int unsigned GAP_CYC  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        nxt,
  output logic        wrt,
  output logic [15:0] cmd,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] steer_pot,
  output logic [11:0] batt,
  output logic        rr_vld,
  input  logic        host_req,
  input  logic [2:0]  host_chnl,
  output logic        host_ack,
  output logic [11:0] host_data,
  output logic        busy
);

  typedef enum logic [2:0] {StIdle, StCmd, StWait1, StGap, StRead, StWait2, StStore} state_t;

  state_t      r_state, w_state_nxt;
  logic        w_start_host, w_start_rr;
  logic [2:0]  w_rr_chnl, w_chnl;
  logic [11:0] w_store;
  logic        r_src_host, r_last_host, r_pend;
  logic [1:0]  r_rr_ptr;
  logic [3:0]  r_gap_cnt;
  logic [11:0] r_sample;
  logic [15:0] r_cmd;
  logic        r_wrt, r_rr_vld, r_host_ack, r_busy;
  logic [11:0] r_lft, r_rght, r_steer, r_batt, r_host_data;
  logic        w_unused;

  // Upper status bits of the ADC frame carry no data
  assign w_unused = ^rd_data[15:12];

  // Slot lookup for the round-robin pointer
  always_comb begin
    w_rr_chnl = CH_LFT;
    case (r_rr_ptr)
      2'd0: w_rr_chnl = CH_LFT;
      2'd1: w_rr_chnl = CH_RGHT;
      2'd2: w_rr_chnl = CH_STEER;
      default: w_rr_chnl = CH_BATT;
    endcase
  end

  // Next-state and grant decision; after a host conversion a waiting RR slot goes first.
  // host_req is ignored during the ack cycle since the host has not yet seen the ack.
  always_comb begin
    w_state_nxt  = r_state;
    w_start_host = 1'b0;
    w_start_rr   = 1'b0;
    case (r_state)
      StIdle: begin
        if (host_req && !r_host_ack && !(r_last_host && (r_pend || nxt))) begin
          w_start_host = 1'b1;
          w_state_nxt  = StCmd;
        end else if (nxt || r_pend) begin
          w_start_rr  = 1'b1;
          w_state_nxt = StCmd;
        end
      end
      StCmd:   w_state_nxt = StWait1;
      StWait1: if (done) w_state_nxt = StGap;
      StGap:   if (r_gap_cnt == 4'(GAP_CYC - 1)) w_state_nxt = StRead;
      StRead:  w_state_nxt = StWait2;
      StWait2: if (done) w_state_nxt = StStore;
      StStore: w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  assign w_chnl = w_start_host ? host_chnl : w_rr_chnl;

`ifdef A2D_AVG_EN
  logic [11:0] w_old;
  logic [12:0] w_sum;
  logic [3:0]  r_first;

  // Rounded average with the held value; the first sample after reset is taken raw
  always_comb begin
    w_old = r_lft;
    case (r_rr_ptr)
      2'd0: w_old = r_lft;
      2'd1: w_old = r_rght;
      2'd2: w_old = r_steer;
      default: w_old = r_batt;
    endcase
    w_sum   = {1'b0, w_old} + {1'b0, r_sample} + 13'd1;
    w_store = r_first[r_rr_ptr] ? r_sample : w_sum[12:1];
  end
`else
  assign w_store = r_sample;
`endif

  // FSM state, gap counter, pending flag and registered strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_gap_cnt   <= 4'd0;
      r_pend      <= 1'b0;
      r_src_host  <= 1'b0;
      r_last_host <= 1'b0;
      r_cmd       <= 16'h0000;
      r_wrt       <= 1'b0;
      r_rr_vld    <= 1'b0;
      r_host_ack  <= 1'b0;
      r_busy      <= 1'b0;
      r_sample    <= 12'h000;
    end else begin
      r_state    <= w_state_nxt;
      r_gap_cnt  <= (r_state == StGap) ? r_gap_cnt + 4'd1 : 4'd0;
      r_wrt      <= (w_state_nxt == StCmd) || (w_state_nxt == StRead);
      r_rr_vld   <= (r_state == StStore) && !r_src_host;
      r_host_ack <= (r_state == StStore) && r_src_host;
      r_busy     <= (w_state_nxt != StIdle) || (r_state == StStore);
      // One pending slot: served pending with a fresh nxt keeps exactly one queued
      if (w_start_rr) r_pend <= r_pend & nxt;
      else if (nxt)   r_pend <= 1'b1;
      if (w_start_host || w_start_rr) begin
        r_cmd       <= {2'b00, w_chnl, 11'h000};
        r_src_host  <= w_start_host;
        r_last_host <= w_start_host;
      end
      if ((r_state == StWait2) && done) r_sample <= rd_data[11:0];
    end
  end

  // Result registers and round-robin pointer, updated only in STORE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr    <= 2'd0;
      r_lft       <= 12'h000;
      r_rght      <= 12'h000;
      r_steer     <= 12'h000;
      r_batt      <= 12'h000;
      r_host_data <= 12'h000;
`ifdef A2D_AVG_EN
      r_first     <= 4'hF;
`endif
    end else if (r_state == StStore) begin
      if (r_src_host) begin
        r_host_data <= r_sample;
      end else begin
        case (r_rr_ptr)
          2'd0: r_lft   <= w_store;
          2'd1: r_rght  <= w_store;
          2'd2: r_steer <= w_store;
          default: r_batt <= w_store;
        endcase
        r_rr_ptr <= r_rr_ptr + 2'd1;
`ifdef A2D_AVG_EN
        r_first[r_rr_ptr] <= 1'b0;
`endif
      end
    end
  end

  assign wrt       = r_wrt;
  assign cmd       = r_cmd;
  assign lft_ld    = r_lft;
  assign rght_ld   = r_rght;
  assign steer_pot = r_steer;
  assign batt      = r_batt;
  assign rr_vld    = r_rr_vld;
  assign host_ack  = r_host_ack;
  assign host_data = r_host_data;
  assign busy      = r_busy;

endmodule
